// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a data memory port that allows
// one outstanding access; every output comes straight from a register.
module dmem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s0_valid,
  input  logic            s0_write,
  input  logic [3:0]      s0_wstrb,
  input  logic [XLEN-1:0] s0_addr,
  input  logic [XLEN-1:0] s0_wdata,
  output logic [XLEN-1:0] s0_rdata,
  output logic            s0_ready,
  input  logic            s1_valid,
  input  logic            s1_write,
  input  logic [3:0]      s1_wstrb,
  input  logic [XLEN-1:0] s1_addr,
  input  logic [XLEN-1:0] s1_wdata,
  output logic [XLEN-1:0] s1_rdata,
  output logic            s1_ready,
  output logic            m_valid,
  output logic            m_write,
  output logic [3:0]      m_wstrb,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic [XLEN-1:0] m_rdata,
  input  logic            m_ready,
  output logic            busy,
  output logic            owner
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state;
  logic   last_grant;
  logic   grant;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant = s1_valid;
    if (s0_valid && s1_valid) begin
      grant = ~last_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      busy       <= 1'b0;
      m_valid    <= 1'b0;
      m_write    <= 1'b0;
      m_wstrb    <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      s0_ready   <= 1'b0;
      s1_ready   <= 1'b0;
      s0_rdata   <= '0;
      s1_rdata   <= '0;
    end else begin
      s0_ready <= 1'b0;
      s1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            owner      <= grant;
            last_grant <= grant;
            busy       <= 1'b1;
            m_valid    <= 1'b1;
            m_write    <= grant ? s1_write : s0_write;
            m_wstrb    <= grant ? s1_wstrb : s0_wstrb;
            m_addr     <= grant ? s1_addr  : s0_addr;
            m_wdata    <= grant ? s1_wdata : s0_wdata;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // Read data is returned for stores too, so it is captured unconditionally.
          if (m_ready) begin
            m_valid <= 1'b0;
            if (owner) begin
              s1_rdata <= m_rdata;
              s1_ready <= 1'b1;
            end else begin
              s0_rdata <= m_rdata;
              s0_ready <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
